shift_seq: RTL and testbench

Iterative shift/rotate responder for the 16-bit datapath. It executes rol/sll/ror/srl, the same operations as the ALU's register and immediate shift ops, one bit position per clock instead of through a barrel shifter. It sits beside the ALU in execute and is driven by a start/busy/done handshake from the stall logic. Result semantics are bit-identical to the combinational ALU shift results for the same Rs and shift amount.

---
 rtl/shift_seq_pkg.sv | 20 ++
 rtl/shift_seq_step.sv | 30 +++
 rtl/shift_seq.sv | 164 ++++++++++++++++
 tb/tb_shift_seq.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// -----------------------------------------------------------------------------
// shift_seq_pkg
// Shared definitions for the iterative shift/rotate responder.
//   OP_*    : operation codes, identical to the ALU funct encoding for shifts
//   state_t : FSM state encoding used by shift_seq
// -----------------------------------------------------------------------------
package shift_seq_pkg;

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage : shift_seq_pkg

// File: rtl/shift_seq_step.sv
// -----------------------------------------------------------------------------
// shift_seq_step
// Combinational one-position shift/rotate selected by op.
// Ports:
//   op       in  2      operation (OP_ROL / OP_SLL / OP_ROR / OP_SRL)
//   data_in  in  WIDTH  value to shift
//   data_out out WIDTH  value shifted by exactly one position
// -----------------------------------------------------------------------------
module shift_seq_step
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    always_comb begin
        data_out = data_in;
        case (op)
            OP_ROL:  data_out = {data_in[WIDTH-2:0], data_in[WIDTH-1]};
            OP_SLL:  data_out = {data_in[WIDTH-2:0], 1'b0};
            OP_ROR:  data_out = {data_in[0], data_in[WIDTH-1:1]};
            OP_SRL:  data_out = {1'b0, data_in[WIDTH-1:1]};
            default: data_out = data_in;
        endcase
    end

endmodule : shift_seq_step

// File: rtl/shift_seq.sv
// -----------------------------------------------------------------------------
// shift_seq
// Iterative shift/rotate responder: rol/sll/ror/srl one bit position per clock
// (two per clock when SHIFT_SEQ_DOUBLE_STEP_EN is defined), bit-identical to
// the combinational ALU shift result for the same operand and amount.
//
// Build option:
//   SHIFT_SEQ_DOUBLE_STEP_EN  shift two positions per SHIFT cycle while the
//                             remaining count is >= 2 (latency ceil(n/2)+1)
//
// Ports:
//   clk      in  1      system clock, rising edge
//   rst      in  1      synchronous reset, active high
//   start    in  1      request, only sampled while busy=0
//   op       in  2      00 rol, 01 sll, 10 ror, 11 srl
//   data_in  in  WIDTH  operand (Rs)
//   amt      in  AMT_W  shift amount
//   busy     out 1      operation in flight
//   done     out 1      one-cycle pulse, res valid
//   res      out WIDTH  result, held until the next accepted operation completes
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; busy=0
// ST_SHIFT | working register shifting, count holds remaining positions
// ST_DONE  | done pulse, res valid; always returns to ST_IDLE
// -----------------------------------------------------------------------------
module shift_seq
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [AMT_W-1:0] count_q, count_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] step1;
    logic [WIDTH-1:0] shift_val;
    logic [AMT_W-1:0] dec;
    logic [AMT_W-1:0] count_next;

`ifdef SHIFT_SEQ_DOUBLE_STEP_EN
    logic [WIDTH-1:0] step2;

    shift_seq_step #(.WIDTH(WIDTH)) u_step_a (
        .op       (op_q),
        .data_in  (work_q),
        .data_out (step1)
    );

    shift_seq_step #(.WIDTH(WIDTH)) u_step_b (
        .op       (op_q),
        .data_in  (step1),
        .data_out (step2)
    );

    // A lone remaining position takes the single-step path so odd counts
    // never overshoot.
    always_comb begin
        shift_val = step1;
        dec       = AMT_W'(1);
        if (count_q >= AMT_W'(2)) begin
            shift_val = step2;
            dec       = AMT_W'(2);
        end
    end
`else
    shift_seq_step #(.WIDTH(WIDTH)) u_step (
        .op       (op_q),
        .data_in  (work_q),
        .data_out (step1)
    );

    assign shift_val = step1;
    assign dec       = AMT_W'(1);
`endif

    assign count_next = count_q - dec;

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        count_d = count_q;
        op_d    = op_q;
        res_d   = res_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = op;
                    work_d  = data_in;
                    count_d = amt;
                    if (amt == '0) begin
                        // Zero amount: result is the operand, straight to done.
                        state_d = ST_DONE;
                        res_d   = data_in;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                work_d  = shift_val;
                count_d = count_next;
                if (count_next == '0) begin
                    // Capture on the last shift so res is valid with done.
                    state_d = ST_DONE;
                    res_d   = shift_val;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs registered alongside the state so they are glitch-free.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            count_q <= '0;
            op_q    <= OP_ROL;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            count_q <= count_d;
            op_q    <= op_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign res  = res_q;

endmodule : shift_seq

// File: tb/tb_shift_seq.sv
// -----------------------------------------------------------------------------
// tb_shift_seq
// Self-checking bench for shift_seq. Reference results come from the ALU
// shift expressions evaluated with plain arithmetic; expected latency follows
// the build mode (SHIFT_SEQ_DOUBLE_STEP_EN or not).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_shift_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] data_in;
    logic [3:0]  amt;
    logic        busy;
    logic        done;
    logic [15:0] res;

    int n_vec;
    int n_err;

    shift_seq #(.WIDTH(16), .AMT_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .data_in (data_in),
        .amt     (amt),
        .busy    (busy),
        .done    (done),
        .res     (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU reference: rol (Rs<<k)|(Rs>>(16-k)), sll Rs<<k, ror {Rs,Rs}>>k, srl Rs>>k.
    function automatic logic [15:0] ref_shift(input logic [1:0] o, input logic [15:0] d, input int k);
        logic [31:0] dd;
        logic [31:0] rr;
        dd = {16'h0000, d};
        rr = {d, d};
        case (o)
            2'b00:   return 16'((dd << k) | (dd >> (16 - k)));
            2'b01:   return 16'(dd << k);
            2'b10:   return 16'(rr >> k);
            default: return 16'(dd >> k);
        endcase
    endfunction

    // Cycle in which done is expected, counting the start edge as the end of cycle 0.
    function automatic int exp_lat(input int k);
`ifdef SHIFT_SEQ_DOUBLE_STEP_EN
        return (k + 1) / 2 + 1;
`else
        return k + 1;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation from an idle cycle and observes it. lat=-1 on timeout.
    // hs_ok clears if busy drops before done, or busy/done linger after done.
    task automatic run_op(input logic [1:0] o, input logic [15:0] d, input logic [3:0] k,
                          output logic [15:0] r, output int lat, output bit hs_ok);
        int guard;
        guard = 0;
        hs_ok = 1'b1;
        lat   = -1;
        r     = 16'hxxxx;
        while (busy !== 1'b0 && guard < 50) begin
            tick();
            guard++;
        end
        op      = o;
        data_in = d;
        amt     = k;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            // Operands are don't-care after acceptance; scramble them.
            op      = 2'($urandom);
            data_in = 16'($urandom);
            amt     = 4'($urandom);
            if (busy !== 1'b1) hs_ok = 1'b0;
            if (done === 1'b1) begin
                lat = c;
                r   = res;
                break;
            end
            tick();
        end
        if (lat > 0) begin
            tick();
            if (busy !== 1'b0 || done !== 1'b0) hs_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        start   = 1'b1;
        op      = 2'b01;
        data_in = 16'hA5A5;
        amt     = 4'd3;
        repeat (3) tick();
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++;
        if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_vec++;
        if (res !== 16'h0000) begin n_err++; $display("FAIL reset_res: got %h want 0000", res); end
        rst   = 1'b0;
        start = 1'b0;
        tick();
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_directed();
        logic [1:0]  t_op [5]  = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
        logic [15:0] t_d  [5]  = '{16'h8001, 16'h0001, 16'h8000, 16'hFFFF, 16'h1234};
        logic [3:0]  t_k  [5]  = '{4'd1, 4'd4, 4'd15, 4'd15, 4'd0};
        logic [15:0] t_r  [5]  = '{16'h0003, 16'h1000, 16'h0001, 16'h8000, 16'h1234};
        logic [15:0] r;
        int          lat;
        bit          hs;
        for (int i = 0; i < 5; i++) begin
            run_op(t_op[i], t_d[i], t_k[i], r, lat, hs);
            n_vec++;
            if (r !== t_r[i]) begin
                n_err++; $display("FAIL directed_res[%0d]: got %h want %h", i, r, t_r[i]);
            end
            n_vec++;
            if (lat != exp_lat(int'(t_k[i]))) begin
                n_err++; $display("FAIL directed_lat[%0d]: got %0d want %0d", i, lat, exp_lat(int'(t_k[i])));
            end
            n_vec++;
            if (hs !== 1'b1) begin
                n_err++; $display("FAIL directed_handshake[%0d]: got %b want 1", i, hs);
            end
        end
    endtask

    task automatic test_ignore_start();
        int          e;
        int          dones;
        int          dc;
        logic [15:0] r;
        bit          busy_ok;
        int          lat2;
        e       = exp_lat(4);
        dones   = 0;
        dc      = -1;
        r       = 16'h0000;
        busy_ok = 1'b1;
        op      = 2'b00;
        data_in = 16'h00F0;
        amt     = 4'd4;
        start   = 1'b1;
        tick();
        for (int c = 1; c <= e; c++) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                dones++;
                dc = c;
                r  = res;
            end
            start   = (c == 2 || c == e);
            op      = 2'($urandom);
            data_in = 16'($urandom);
            amt     = 4'($urandom);
            tick();
        end
        n_vec++;
        if (dones != 1) begin n_err++; $display("FAIL ignore_done_count: got %0d want 1", dones); end
        n_vec++;
        if (dc != e) begin n_err++; $display("FAIL ignore_done_cycle: got %0d want %0d", dc, e); end
        n_vec++;
        if (r !== 16'h0F00) begin n_err++; $display("FAIL ignore_res: got %h want 0f00", r); end
        n_vec++;
        if (busy_ok !== 1'b1) begin n_err++; $display("FAIL ignore_busy: got %b want 1", busy_ok); end
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL ignore_stray_start: busy=%b done=%b want 0 0", busy, done);
        end
        n_vec++;
        if (res !== 16'h0F00) begin n_err++; $display("FAIL ignore_res_hold: got %h want 0f00", res); end
        // Earliest legal accept: the cycle right after done.
        op      = 2'b11;
        data_in = 16'h00F0;
        amt     = 4'd2;
        start   = 1'b1;
        tick();
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL back_to_back_accept: busy=%b want 1", busy); end
        lat2 = -1;
        for (int c = 1; c <= 40; c++) begin
            if (done === 1'b1) begin
                lat2 = c;
                r    = res;
                break;
            end
            tick();
        end
        n_vec++;
        if (lat2 != exp_lat(2)) begin n_err++; $display("FAIL back_to_back_lat: got %0d want %0d", lat2, exp_lat(2)); end
        n_vec++;
        if (r !== 16'h003C) begin n_err++; $display("FAIL back_to_back_res: got %h want 003c", r); end
        tick();
    endtask

    task automatic test_reset_mid();
        int          dones;
        logic [15:0] r;
        int          lat;
        bit          hs;
        op      = 2'b01;
        data_in = 16'($urandom) | 16'h0001;
        amt     = 4'd8;
        start   = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_vec++;
        if (done !== 1'b0) begin n_err++; $display("FAIL rstmid_done: got %b want 0", done); end
        n_vec++;
        if (res !== 16'h0000) begin n_err++; $display("FAIL rstmid_res: got %h want 0000", res); end
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            if (done === 1'b1 || busy === 1'b1) dones++;
            tick();
        end
        n_vec++;
        if (dones != 0) begin n_err++; $display("FAIL rstmid_stray_activity: got %0d want 0", dones); end
        run_op(2'b11, 16'h0100, 4'd8, r, lat, hs);
        n_vec++;
        if (r !== 16'h0001) begin n_err++; $display("FAIL rstmid_fresh_res: got %h want 0001", r); end
        n_vec++;
        if (lat != exp_lat(8)) begin n_err++; $display("FAIL rstmid_fresh_lat: got %0d want %0d", lat, exp_lat(8)); end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [15:0] d;
        logic [3:0]  k;
        logic [15:0] r;
        logic [15:0] want;
        int          lat;
        bit          hs;
        for (int i = 0; i < 1000; i++) begin
            o    = 2'(i % 4);
            k    = 4'((i / 4) % 16);
            d    = 16'($urandom);
            want = ref_shift(o, d, int'(k));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) tick();
            run_op(o, d, k, r, lat, hs);
            n_vec++;
            if (r !== want) begin
                n_err++; $display("FAIL random_res[%0d] op=%0d d=%h k=%0d: got %h want %h", i, o, d, k, r, want);
            end
            n_vec++;
            if (lat != exp_lat(int'(k))) begin
                n_err++; $display("FAIL random_lat[%0d] k=%0d: got %0d want %0d", i, k, lat, exp_lat(int'(k)));
            end
            n_vec++;
            if (hs !== 1'b1) begin
                n_err++; $display("FAIL random_handshake[%0d]: got %b want 1", i, hs);
            end
        end
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        data_in = 16'h0000;
        amt     = 4'd0;
        tick();
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_shift_seq
